// File: rtl/dht11_sensor_reader_pkg.sv
// Shared types and frame helpers for the DHT11 host receiver.
// Frame bytes arrive MSB-first: hum_int, hum_dec, temp_int, temp_dec, checksum.
package greenhouse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK_LOW,
    ACK_LOW,
    ACK_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } dht_state_t;

  localparam int unsigned DHT_FRAME_BITS = 40;
  localparam int unsigned F_OFFSET       = 32;

  localparam int unsigned B_HUM_INT  = 0;
  localparam int unsigned B_HUM_DEC  = 1;
  localparam int unsigned B_TEMP_INT = 2;
  localparam int unsigned B_TEMP_DEC = 3;
  localparam int unsigned B_CHECKSUM = 4;

  function automatic logic [7:0] frame_byte(input logic [DHT_FRAME_BITS-1:0] frame,
                                            input int unsigned idx);
    return frame[DHT_FRAME_BITS-1-8*idx -: 8];
  endfunction

  // Sum wraps at 8 bits, matching the sensor's own checksum arithmetic.
  function automatic logic checksum_ok(input logic [DHT_FRAME_BITS-1:0] frame);
    logic [7:0] sum;
    sum = frame_byte(frame, B_HUM_INT) + frame_byte(frame, B_HUM_DEC)
        + frame_byte(frame, B_TEMP_INT) + frame_byte(frame, B_TEMP_DEC);
    return sum == frame_byte(frame, B_CHECKSUM);
  endfunction

  function automatic logic [11:0] c_to_f(input logic [7:0] celsius);
    logic [11:0] scaled;
    scaled = 12'(celsius) * 12'd9;
    return scaled / 12'd5 + 12'(F_OFFSET);
  endfunction

endpackage

// File: rtl/dht11_sensor_reader_us_tick_gen.sv
// Free-running prescaler: one-cycle us_tick every CLK_HZ/1e6 clocks.
module us_tick_gen #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  output logic us_tick
);

  localparam int unsigned DIV = (CLK_HZ / 1000000 > 1) ? CLK_HZ / 1000000 : 1;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
      us_tick <= 1'b0;
    end else if (div_cnt == CW'(DIV - 1)) begin
      div_cnt <= '0;
      us_tick <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      us_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dht11_sensor_reader.sv
// DHT11 single-wire host: polls the sensor, times the 40-bit reply,
// verifies the checksum and holds humidity and Fahrenheit temperature.
module dht11_sensor_reader #(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned POLL_US       = 2000000,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned BIT_THRESH_US = 48
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        DHT_IN,
  output logic        DHT_DRIVE_LOW,
  output logic [11:0] TEMP_F,
  output logic [7:0]  HUM,
  output logic        DATA_VALID,
  output logic        CRC_ERR,
  output logic        TIMEOUT_ERR,
  output logic        BUSY
);

  import greenhouse_pkg::*;

  dht_state_t                state;
  logic [31:0]               us_count;
  logic [5:0]                bit_cnt;
  logic [DHT_FRAME_BITS-1:0] shift_reg;
  logic                      us_tick;

  logic dht_meta, dht_sync, dht_prev;
  logic dht_fall, dht_rise;
  logic in_wait, edge_seen;

  us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .us_tick  (us_tick)
  );

  // Sync stages reset high to match the pulled-up idle line.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      dht_meta <= 1'b1;
      dht_sync <= 1'b1;
      dht_prev <= 1'b1;
    end else begin
      dht_meta <= DHT_IN;
      dht_sync <= dht_meta;
      dht_prev <= dht_sync;
    end
  end

  assign dht_fall = dht_prev & ~dht_sync;
  assign dht_rise = ~dht_prev & dht_sync;

  always_comb begin
    in_wait   = 1'b0;
    edge_seen = 1'b0;
    case (state)
      WAIT_ACK_LOW, ACK_HIGH, BIT_HIGH: begin
        in_wait   = 1'b1;
        edge_seen = dht_fall;
      end
      ACK_LOW, BIT_LOW: begin
        in_wait   = 1'b1;
        edge_seen = dht_rise;
      end
      default: ;
    endcase
  end

  // Timeout is checked once for all wait states; an edge on the same cycle wins.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      us_count      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      DHT_DRIVE_LOW <= 1'b0;
      TEMP_F        <= '0;
      HUM           <= '0;
      DATA_VALID    <= 1'b0;
      CRC_ERR       <= 1'b0;
      TIMEOUT_ERR   <= 1'b0;
      BUSY          <= 1'b0;
    end else begin
      DATA_VALID  <= 1'b0;
      CRC_ERR     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      if (us_tick) us_count <= us_count + 32'd1;

      if (in_wait && !edge_seen && us_count >= TIMEOUT_US) begin
        state       <= IDLE;
        us_count    <= '0;
        TIMEOUT_ERR <= 1'b1;
        BUSY        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (us_count >= POLL_US) begin
              state         <= START;
              us_count      <= '0;
              DHT_DRIVE_LOW <= 1'b1;
              BUSY          <= 1'b1;
            end
          end
          START: begin
            if (us_count >= START_LOW_US) begin
              state         <= WAIT_ACK_LOW;
              us_count      <= '0;
              DHT_DRIVE_LOW <= 1'b0;
            end
          end
          WAIT_ACK_LOW: begin
            if (edge_seen) begin
              state    <= ACK_LOW;
              us_count <= '0;
            end
          end
          ACK_LOW: begin
            if (edge_seen) begin
              state    <= ACK_HIGH;
              us_count <= '0;
            end
          end
          ACK_HIGH: begin
            if (edge_seen) begin
              state    <= BIT_LOW;
              us_count <= '0;
              bit_cnt  <= '0;
            end
          end
          BIT_LOW: begin
            if (edge_seen) begin
              state    <= BIT_HIGH;
              us_count <= '0;
            end
          end
          BIT_HIGH: begin
            if (edge_seen) begin
              shift_reg <= {shift_reg[DHT_FRAME_BITS-2:0], (us_count > BIT_THRESH_US)};
              bit_cnt   <= bit_cnt + 6'd1;
              us_count  <= '0;
              if (bit_cnt == 6'(DHT_FRAME_BITS - 1)) state <= CHECK;
              else                                   state <= BIT_LOW;
            end
          end
          CHECK: begin
            if (checksum_ok(shift_reg)) begin
              HUM        <= frame_byte(shift_reg, B_HUM_INT);
              TEMP_F     <= c_to_f(frame_byte(shift_reg, B_TEMP_INT));
              DATA_VALID <= 1'b1;
            end else begin
              CRC_ERR <= 1'b1;
            end
            state    <= IDLE;
            us_count <= '0;
            BUSY     <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            us_count <= '0;
            BUSY     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht11_sensor_reader.sv
// Directed and randomized bench for dht11_sensor_reader with a wired-AND
// sensor model and a byte-level reference of the expected readings.
module tb_dht11_sensor_reader;

  localparam int unsigned CLK_HZ        = 2000000;
  localparam int unsigned POLL_US       = 100;
  localparam int unsigned START_LOW_US  = 20;
  localparam int unsigned TIMEOUT_US    = 200;
  localparam int unsigned BIT_THRESH_US = 48;
  localparam int          CPU           = 2;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        line     = 1'b1;
  logic        DHT_IN;
  logic        DHT_DRIVE_LOW;
  logic [11:0] TEMP_F;
  logic [7:0]  HUM;
  logic        DATA_VALID, CRC_ERR, TIMEOUT_ERR, BUSY;

  int n_cmp = 0, n_bad = 0;
  int dv_cnt = 0, crc_cnt = 0, to_cnt = 0;
  int exp_hum = 0, exp_tf = 0;

  assign DHT_IN = line & ~DHT_DRIVE_LOW;

  dht11_sensor_reader #(
    .CLK_HZ        (CLK_HZ),
    .POLL_US       (POLL_US),
    .START_LOW_US  (START_LOW_US),
    .TIMEOUT_US    (TIMEOUT_US),
    .BIT_THRESH_US (BIT_THRESH_US)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .RESET_N       (RESET_N),
    .DHT_IN        (DHT_IN),
    .DHT_DRIVE_LOW (DHT_DRIVE_LOW),
    .TEMP_F        (TEMP_F),
    .HUM           (HUM),
    .DATA_VALID    (DATA_VALID),
    .CRC_ERR       (CRC_ERR),
    .TIMEOUT_ERR   (TIMEOUT_ERR),
    .BUSY          (BUSY)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (DATA_VALID === 1'b1)  dv_cnt++;
    if (CRC_ERR === 1'b1)     crc_cnt++;
    if (TIMEOUT_ERR === 1'b1) to_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_range(input string tag, input int got, input int lo, input int hi);
    n_cmp++;
    assert ((got >= lo && got <= hi) === 1'b1) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic hold(input logic lvl, input int us);
    line = lvl;
    repeat (us * CPU) @(negedge CLOCK_50);
  endtask

  task automatic wait_drive(input logic val, input int budget, output int cyc);
    cyc = 0;
    while (DHT_DRIVE_LOW !== val && cyc < budget) begin
      @(negedge CLOCK_50);
      cyc++;
    end
  endtask

  task automatic start_txn();
    int c;
    wait_drive(1'b1, 2000, c);
    check("start_seen", DHT_DRIVE_LOW, 1);
    check("busy_start", BUSY, 1);
    wait_drive(1'b0, 200, c);
    check_range("start_low", c, 37, 44);
  endtask

  // Drives the ack and nbits data bits; ends with the line pulled low (final falling edge).
  // abort_bit >= 0 asserts reset partway through that bit's high phase instead.
  task automatic send_frame(input logic [39:0] fr, input int nbits, input bit jitter,
                            input int abort_bit);
    int w;
    hold(1'b1, 20);
    hold(1'b0, 80);
    hold(1'b1, 80);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, 20);
      if (fr[39-i]) w = jitter ? int'($urandom_range(75, 62)) : 70;
      else          w = jitter ? int'($urandom_range(34, 22)) : 28;
      if (i == abort_bit) begin
        hold(1'b1, 10);
        #1 RESET_N = 1'b0;
        #1;
        exp_hum = 0;
        exp_tf  = 0;
        check("rst_drive", DHT_DRIVE_LOW, 0);
        check("rst_temp", TEMP_F, 0);
        check("rst_hum", HUM, 0);
        check("rst_busy", BUSY, 0);
        line = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        return;
      end
      hold(1'b1, w);
    end
    line = 1'b0;
  endtask

  task automatic run_full(input int h, input int hd, input int t, input int td,
                          input int chk, input bit jitter);
    int dv0, crc0, to0;
    bit good;
    logic [39:0] fr;
    dv0  = dv_cnt;
    crc0 = crc_cnt;
    to0  = to_cnt;
    fr   = {8'(h), 8'(hd), 8'(t), 8'(td), 8'(chk)};
    good = ((h + hd + t + td) % 256) == chk;
    if (good) begin
      exp_hum = h;
      exp_tf  = (t * 9) / 5 + 32;
    end
    send_frame(fr, 40, jitter, -1);
    repeat (3) @(negedge CLOCK_50);
    check("lat_early", good ? DATA_VALID : CRC_ERR, 0);
    @(negedge CLOCK_50);
    check("lat_pulse", good ? DATA_VALID : CRC_ERR, 1);
    hold(1'b0, 16);
    line = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    check("dv_count", dv_cnt - dv0, good ? 1 : 0);
    check("crc_count", crc_cnt - crc0, good ? 0 : 1);
    check("no_timeout", to_cnt - to0, 0);
    check("hum", HUM, exp_hum);
    check("temp_f", TEMP_F, exp_tf);
    check("busy_idle", BUSY, 0);
  endtask

  initial begin
    int c, dv0, h, hd, t, td, chk;
    logic [39:0] fr;

    RESET_N = 1'b0;
    line    = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    check("reset_drive", DHT_DRIVE_LOW, 0);
    check("reset_temp", TEMP_F, 0);
    check("reset_hum", HUM, 0);
    check("reset_dv", DATA_VALID, 0);
    check("reset_crc", CRC_ERR, 0);
    check("reset_to", TIMEOUT_ERR, 0);
    check("reset_busy", BUSY, 0);
    RESET_N = 1'b1;

    wait_drive(1'b1, 400, c);
    check_range("poll_first", c, 196, 206);
    check("busy_first", BUSY, 1);
    check("first_temp", TEMP_F, 0);
    check("first_hum", HUM, 0);
    wait_drive(1'b0, 200, c);
    check_range("start_low_first", c, 37, 44);

    run_full(45, 0, 25, 0, 70, 1'b0);
    check("hum45", HUM, 45);
    check("temp77", TEMP_F, 77);

    start_txn();
    run_full(45, 0, 25, 0, 71, 1'b0);

    // No response: line stays high after release.
    wait_drive(1'b1, 2000, c);
    wait_drive(1'b0, 200, c);
    c = 0;
    while (TIMEOUT_ERR !== 1'b1 && c < 600) begin
      @(negedge CLOCK_50);
      c++;
    end
    check_range("timeout_lat", c, 396, 406);
    wait_drive(1'b1, 600, c);
    check_range("repoll", c, 196, 206);
    check("to_keep_hum", HUM, exp_hum);
    check("to_keep_temp", TEMP_F, exp_tf);
    wait_drive(1'b0, 200, c);
    check_range("start_low_repoll", c, 37, 44);

    // Sensor goes silent after bit 17.
    dv0 = dv_cnt;
    send_frame({8'd99, 8'd0, 8'd0, 8'd0, 8'd99}, 17, 1'b1, -1);
    hold(1'b0, 20);
    line = 1'b1;
    c = 0;
    while (TIMEOUT_ERR !== 1'b1 && c < 1200) begin
      @(negedge CLOCK_50);
      c++;
    end
    check("partial_timeout", TIMEOUT_ERR, 1);
    check("partial_no_dv", dv_cnt - dv0, 0);
    check("partial_hum", HUM, exp_hum);

    start_txn();
    run_full(99, 0, 0, 0, 99, 1'b1);

    // Reset during the 10th data bit.
    start_txn();
    send_frame({8'd60, 8'd1, 8'd30, 8'd2, 8'd93}, 40, 1'b1, 9);
    dv0 = dv_cnt;
    start_txn();
    check("no_dv_after_reset", dv_cnt - dv0, 0);
    h  = int'($urandom_range(255, 0));
    hd = int'($urandom_range(255, 0));
    t  = int'($urandom_range(255, 0));
    td = int'($urandom_range(255, 0));
    run_full(h, hd, t, td, (h + hd + t + td) % 256, 1'b1);

    for (int k = 0; k < 2; k++) begin
      h   = int'($urandom_range(255, 0));
      hd  = int'($urandom_range(255, 0));
      t   = (k == 0) ? 255 : int'($urandom_range(255, 0));
      td  = int'($urandom_range(255, 0));
      chk = (h + hd + t + td) % 256;
      if (k == 1 && $urandom_range(1, 0) == 1) chk = chk ^ (1 << $urandom_range(7, 0));
      start_txn();
      run_full(h, hd, t, td, chk, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (150000) @(posedge CLOCK_50);
    $display("FAIL watchdog: observed no completion expected finish within 150000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
